pmod_als_spi_responder: RTL and testbench

SPI responder that emulates the Pmod ALS light sensor's ADC081S021 on the sensor side of the link. It drives `sdo` from `cs`/`sck` produced by an SPI master on the same board. Each frame carries an 8-bit light sample supplied by user logic, such as switches, a counter or a ramp. It lets the light-sensor exercises run and be verified without the physical sensor.

---
 rtl/pmod_als_spi_responder_if.sv | 36 +++
 rtl/pmod_als_spi_responder.sv | 209 ++++++++++++++++++++
 tb/tb_pmod_als_spi_responder.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pmod_als_spi_responder_if.sv
// -----------------------------------------------------------------------------
// pmod_als_spi_responder_if
//
// Purpose: the four SPI pins between a Pmod ALS style master and the emulated
//          ADC081S021 sensor side.
//
// Signals:
//   cs      chip select, active low, driven by the master
//   sck     serial clock, idle high, driven by the master
//   sdo     serial data from the sensor side to the master
//   sdo_oe  output enable for an external tri-state buffer on sdo
//
// Modports:
//   master  drives cs/sck, receives sdo/sdo_oe
//   slave   receives cs/sck, drives sdo/sdo_oe
// -----------------------------------------------------------------------------
interface pmod_als_spi_responder_if;
    logic cs;
    logic sck;
    logic sdo;
    logic sdo_oe;

    modport master (
        output cs,
        output sck,
        input  sdo,
        input  sdo_oe
    );

    modport slave (
        input  cs,
        input  sck,
        output sdo,
        output sdo_oe
    );
endinterface : pmod_als_spi_responder_if

// File: rtl/pmod_als_spi_responder.sv
// -----------------------------------------------------------------------------
// pmod_als_spi_responder
//
// Purpose: emulates the ADC081S021 light-sensor ADC of a Pmod ALS. A master on
//          the same board clocks 16-bit frames {3'b000, data[7:0], 5'b00000}
//          out of this block, MSB first. The 8-bit data comes from a hold
//          register that user logic loads through sample/sample_load.
//
// Parameters:
//   sync_stages   synchronizer depth on cs and sck, legal range 2..4
//   reset_sample  value of the hold register after reset
//
// Ports:
//   clock        system clock
//   reset        asynchronous, active-high reset
//   spi          slave side of the SPI pin bundle (cs, sck in; sdo, sdo_oe out)
//   sample       next light value
//   sample_load  one-cycle strobe capturing sample into the hold register
//   busy         high from detected cs fall to detected cs rise
//   frame_done   one-cycle pulse after the 16th sck rise of a frame
//   frame_count  number of complete frames, wraps at 16'hFFFF
// -----------------------------------------------------------------------------
module pmod_als_spi_responder #(
    parameter int          sync_stages  = 2,
    parameter logic [7:0]  reset_sample = 8'h00
) (
    input  logic                            clock,
    input  logic                            reset,
    pmod_als_spi_responder_if.slave         spi,
    input  logic [7:0]                      sample,
    input  logic                            sample_load,
    output logic                            busy,
    output logic                            frame_done,
    output logic [15:0]                     frame_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [4:0] last_bit = 5'd15;

    // -------------------------------------------------------------------------
    // Synchronizers and edge detection
    // -------------------------------------------------------------------------
    logic [sync_stages-1:0] cs_sync;
    logic [sync_stages-1:0] sck_sync;
    logic                   cs_prev;
    logic                   sck_prev;
    logic                   cs_fall;
    logic                   cs_rise;
    logic                   sck_fall;
    logic                   sck_rise;

    // Both lines idle high, so the chain resets to 1: releasing reset with
    // the lines idle must not look like a falling edge.
    // NOTE: sequential state is always written with <=, so every flop in a
    // clocked block samples the values from before the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cs_sync  <= '1;
            sck_sync <= '1;
            cs_prev  <= 1'b1;
            sck_prev <= 1'b1;
            cs_fall  <= 1'b0;
            cs_rise  <= 1'b0;
            sck_fall <= 1'b0;
            sck_rise <= 1'b0;
        end else begin
            cs_sync  <= {cs_sync[sync_stages-2:0], spi.cs};
            sck_sync <= {sck_sync[sync_stages-2:0], spi.sck};
            cs_prev  <= cs_sync[sync_stages-1];
            sck_prev <= sck_sync[sync_stages-1];
            // Edge pulses are registered so the FSM sees clean one-cycle
            // strobes from a single flop each.
            cs_fall  <= cs_prev & ~cs_sync[sync_stages-1];
            cs_rise  <= ~cs_prev & cs_sync[sync_stages-1];
            sck_fall <= sck_prev & ~sck_sync[sync_stages-1];
            sck_rise <= ~sck_prev & sck_sync[sync_stages-1];
        end
    end

    // -------------------------------------------------------------------------
    // Hold register: loadable at any time; a frame copies it at cs fall, so a
    // load during a frame only shows up in the next one.
    // -------------------------------------------------------------------------
    logic [7:0]  hold_q;
    logic [15:0] frame_word;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_q <= reset_sample;
        end else if (sample_load) begin
            hold_q <= sample;
        end
    end

    assign frame_word = {3'b000, hold_q, 5'b00000};

    // -------------------------------------------------------------------------
    // Frame FSM: state register / next state / outputs
    // -------------------------------------------------------------------------
    state_t     state_q;
    state_t     state_d;
    logic [4:0] bit_count_q;
    logic       last_rise;

    // The 16th counted rise of a frame; a simultaneous cs rise aborts instead.
    assign last_rise = (state_q == SHIFT) && !cs_rise && sck_rise &&
                       (bit_count_q == last_bit);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the default assignment at the top of a combinational block keeps
    // every path assigned, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end else if (last_rise) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q != IDLE);
        spi.sdo_oe = (state_q != IDLE);
    end

    // -------------------------------------------------------------------------
    // Shift datapath, sdo register and frame counter
    // -------------------------------------------------------------------------
    logic [15:0] shift_q;
    logic        sdo_q;
    logic        frame_done_q;
    logic [15:0] frame_count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q       <= '0;
            bit_count_q   <= '0;
            sdo_q         <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        shift_q     <= frame_word;
                        sdo_q       <= frame_word[15];
                        bit_count_q <= '0;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        sdo_q <= 1'b0;
                    end else if (sck_rise) begin
                        bit_count_q <= bit_count_q + 5'd1;
                        if (last_rise) begin
                            sdo_q         <= 1'b0;
                            frame_done_q  <= 1'b1;
                            frame_count_q <= frame_count_q + 16'd1;
                        end
                    end else if (sck_fall && (bit_count_q != 5'd0)) begin
                        // The master's first sck fall precedes its first
                        // sample, so bit 15 must stay on sdo until one rise
                        // has been counted; later falls advance the word.
                        shift_q <= {shift_q[14:0], 1'b0};
                        sdo_q   <= shift_q[14];
                    end
                end
                DONE: begin
                    // Extra clocks are ignored; the counter rests at 16.
                    sdo_q <= 1'b0;
                end
                default: sdo_q <= 1'b0;
            endcase
        end
    end

    assign spi.sdo     = sdo_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;

endmodule : pmod_als_spi_responder

// File: tb/tb_pmod_als_spi_responder.sv
// -----------------------------------------------------------------------------
// tb_pmod_als_spi_responder
//
// Bench acting as the SPI master. Frames are clocked with half periods of
// HALF system cycles; sdo is sampled at each sck rise. Expected words come
// from a model of the hold register and the frame layout.
// -----------------------------------------------------------------------------
module tb_pmod_als_spi_responder;

    localparam int         SYNC       = 2;
    localparam logic [7:0] RST_SAMPLE = 8'hC3;
    localparam int         HALF       = 8;
    localparam int         LAT        = SYNC + 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  sample;
    logic        sample_load;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_count;

    pmod_als_spi_responder_if spi ();

    pmod_als_spi_responder #(
        .sync_stages  (SYNC),
        .reset_sample (RST_SAMPLE)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .spi         (spi),
        .sample      (sample),
        .sample_load (sample_load),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    always #5 clock = ~clock;

    int          vectors    = 0;
    int          miscompares = 0;
    int          done_seen  = 0;
    logic [7:0]  model_hold;
    logic [15:0] model_count;

    always @(posedge clock) begin
        #1;
        if (frame_done === 1'b1) done_seen++;
    end

    // Bits a master sees on rises 1..n: frame bits 15 downward, then zeros.
    function automatic logic [31:0] expected_bits(input logic [15:0] word, input int n);
        logic [31:0] e;
        e = '0;
        for (int k = 1; k <= n; k++) begin
            e = {e[30:0], (k <= 16) ? word[16-k] : 1'b0};
        end
        return e;
    endfunction

    task automatic load(input logic [7:0] v);
        @(negedge clock);
        sample      = v;
        sample_load = 1'b1;
        model_hold  = v;
        @(negedge clock);
        sample_load = 1'b0;
    endtask

    // One master frame of n rises; optional load of load_val right after
    // rise load_at. Returns the sampled bits and the expected bits.
    task automatic run_frame(input int n, input int load_at, input logic [7:0] load_val,
                             output logic [31:0] rx, output logic [31:0] exp_rx);
        logic [15:0] word;
        int          done_before;
        word        = {3'b000, model_hold, 5'b00000};
        exp_rx      = expected_bits(word, n);
        done_before = done_seen;
        rx          = '0;
        @(negedge clock);
        spi.cs = 1'b0;
        repeat (LAT - 1) @(negedge clock);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_rise_early: got %b expected 0", busy);
        end
        @(negedge clock);
        vectors++;
        if (busy !== 1'b1 || spi.sdo_oe !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_rise: busy=%b sdo_oe=%b expected 1/1", busy, spi.sdo_oe);
        end
        repeat (HALF) @(negedge clock);
        for (int k = 1; k <= n; k++) begin
            spi.sck = 1'b0;
            repeat (HALF) @(negedge clock);
            rx      = {rx[30:0], spi.sdo};
            spi.sck = 1'b1;
            if (k == load_at) load(load_val);
            repeat (HALF) @(negedge clock);
        end
        spi.cs = 1'b1;
        repeat (LAT - 1) @(negedge clock);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_fall_early: got %b expected 1", busy);
        end
        @(negedge clock);
        vectors++;
        if (busy !== 1'b0 || spi.sdo_oe !== 1'b0 || spi.sdo !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_fall: busy=%b sdo_oe=%b sdo=%b expected 0/0/0",
                     busy, spi.sdo_oe, spi.sdo);
        end
        if (n >= 16) model_count = model_count + 16'd1;
        vectors++;
        if (done_seen - done_before != ((n >= 16) ? 1 : 0)) begin
            miscompares++;
            $display("FAIL frame_done_pulses: got %0d expected %0d",
                     done_seen - done_before, (n >= 16) ? 1 : 0);
        end
        vectors++;
        if (frame_count !== model_count) begin
            miscompares++;
            $display("FAIL frame_count: got %h expected %h", frame_count, model_count);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rx, exp_rx;
        vectors++;
        if ({spi.sdo, spi.sdo_oe, busy, frame_done} !== 4'b0000 || frame_count !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_outputs: sdo/oe/busy/done=%b%b%b%b count=%h expected 0000 0000",
                     spi.sdo, spi.sdo_oe, busy, frame_done, frame_count);
        end
        run_frame(16, 0, 8'h00, rx, exp_rx);
        vectors++;
        if (rx[15:0] !== 16'h1860) begin
            miscompares++;
            $display("FAIL reset_sample_frame: got %h expected 1860", rx[15:0]);
        end
    endtask

    task automatic test_normal();
        logic [31:0] rx, exp_rx;
        load(8'hA5);
        run_frame(16, 0, 8'h00, rx, exp_rx);
        vectors++;
        if (rx[15:0] !== 16'h14A0) begin
            miscompares++;
            $display("FAIL normal_frame: got %h expected 14a0", rx[15:0]);
        end
    endtask

    task automatic test_mid_load();
        logic [31:0] rx, exp_rx;
        load(8'h3C);
        run_frame(16, 5, 8'hFF, rx, exp_rx);
        vectors++;
        if (rx[15:0] !== 16'h0780) begin
            miscompares++;
            $display("FAIL mid_load_current: got %h expected 0780", rx[15:0]);
        end
        run_frame(16, 0, 8'h00, rx, exp_rx);
        vectors++;
        if (rx[15:0] !== 16'h1FE0) begin
            miscompares++;
            $display("FAIL mid_load_next: got %h expected 1fe0", rx[15:0]);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rx, exp_rx;
        load(8'h80);
        run_frame(8, 0, 8'h00, rx, exp_rx);
        vectors++;
        if (rx[7:0] !== 8'b0001_0000) begin
            miscompares++;
            $display("FAIL abort_bits: got %b expected 00010000", rx[7:0]);
        end
    endtask

    task automatic test_extra_clocks();
        logic [31:0] rx, exp_rx;
        load(8'h01);
        run_frame(20, 0, 8'h00, rx, exp_rx);
        vectors++;
        if (rx[19:0] !== {16'h0020, 4'h0}) begin
            miscompares++;
            $display("FAIL extra_clocks: got %h expected 00200", rx[19:0]);
        end
    endtask

    task automatic test_wrap_and_reset();
        logic [31:0] rx, exp_rx;
        @(negedge clock);
        force dut.frame_count_q = 16'hFFFF;
        @(negedge clock);
        release dut.frame_count_q;
        model_count = 16'hFFFF;
        @(negedge clock);
        vectors++;
        if (frame_count !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL wrap_preload: got %h expected ffff", frame_count);
        end
        run_frame(16, 0, 8'h00, rx, exp_rx);
        vectors++;
        if (frame_count !== 16'h0000) begin
            miscompares++;
            $display("FAIL wrap: got %h expected 0000", frame_count);
        end
        // Reset in the middle of a frame.
        load(8'h5A);
        @(negedge clock);
        spi.cs = 1'b0;
        repeat (HALF + LAT) @(negedge clock);
        spi.sck = 1'b0;
        repeat (HALF) @(negedge clock);
        spi.sck = 1'b1;
        repeat (HALF) @(negedge clock);
        spi.sck = 1'b0;
        repeat (3) @(negedge clock);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_busy: got %b expected 1", busy);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({spi.sdo, spi.sdo_oe, busy, frame_done} !== 4'b0000 || frame_count !== 16'h0000) begin
            miscompares++;
            $display("FAIL async_reset: sdo/oe/busy/done=%b%b%b%b count=%h expected 0000 0000",
                     spi.sdo, spi.sdo_oe, busy, frame_done, frame_count);
        end
        spi.cs  = 1'b1;
        spi.sck = 1'b1;
        repeat (3) @(negedge clock);
        reset       = 1'b0;
        model_hold  = RST_SAMPLE;
        model_count = 16'h0000;
        run_frame(16, 0, 8'h00, rx, exp_rx);
        vectors++;
        if (rx[15:0] !== 16'h1860) begin
            miscompares++;
            $display("FAIL hold_after_reset: got %h expected 1860", rx[15:0]);
        end
    endtask

    task automatic test_idle_glitch();
        logic [31:0] rx, exp_rx;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if ($urandom_range(0, 1) == 1) spi.sck = ~spi.sck;
            if ($urandom_range(0, 3) == 0) begin
                sample      = 8'($urandom);
                sample_load = 1'b1;
                model_hold  = sample;
            end else begin
                sample_load = 1'b0;
            end
            vectors++;
            if (spi.sdo_oe !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_glitch[%0d]: sdo_oe=%b busy=%b done=%b expected 0/0/0",
                         i, spi.sdo_oe, busy, frame_done);
            end
        end
        @(negedge clock);
        sample_load = 1'b0;
        spi.sck     = 1'b1;
        repeat (HALF) @(negedge clock);
        run_frame(16, 0, 8'h00, rx, exp_rx);
        vectors++;
        if (rx !== exp_rx) begin
            miscompares++;
            $display("FAIL idle_last_load: got %h expected %h", rx, exp_rx);
        end
    endtask

    task automatic test_back_to_back_random();
        logic [31:0] rx, exp_rx;
        int          n;
        int          load_at;
        for (int f = 0; f < 12; f++) begin
            if ($urandom_range(0, 1) == 1) load(8'($urandom));
            n       = $urandom_range(1, 20);
            load_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n) : 0;
            run_frame(n, load_at, 8'($urandom), rx, exp_rx);
            vectors++;
            if (rx !== exp_rx) begin
                miscompares++;
                $display("FAIL random_frame[%0d] n=%0d: got %h expected %h", f, n, rx, exp_rx);
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        spi.cs      = 1'b1;
        spi.sck     = 1'b1;
        sample      = 8'h00;
        sample_load = 1'b0;
        model_hold  = RST_SAMPLE;
        model_count = 16'h0000;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        test_reset();
        test_normal();
        test_mid_load();
        test_abort();
        test_extra_clocks();
        test_wrap_and_reset();
        test_idle_glitch();
        test_back_to_back_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_pmod_als_spi_responder
